// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - req/ack instruction memory bus between prefetch queue and memory
interface instr_prefetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetch FIFO with PC tags and redirect flush
// Optional PQ_ALIGN_CHECK_EN: flags misaligned redirect targets on o_addr_err and halts fetch.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_redirect,
  input  logic [31:0]                   i_redirect_pc,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [31:0]                   o_instr,
  output logic [31:0]                   o_pc,
`ifdef PQ_ALIGN_CHECK_EN
  output logic                          o_addr_err,
`endif
  instr_prefetch_queue_if.master        mem_bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DISCARD} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_fetch_pc;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_instr_q [DEPTH];
  logic [31:0]   r_pc_q    [DEPTH];

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_fetch_en;
  logic          w_can_issue;
  logic [CW-1:0] w_count_next;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_fetch_pc_inc;

`ifdef PQ_ALIGN_CHECK_EN
  logic          r_addr_err;
  assign o_addr_err = r_addr_err;
  assign w_fetch_en = ~r_addr_err;
`else
  assign w_fetch_en = 1'b1;
`endif

  assign w_ack          = r_mem_req & mem_bus.mem_ack;
  assign w_push         = (r_state == ST_WAIT) & w_ack;
  assign w_pop          = o_valid & i_ready;
  assign w_count_next   = r_count + CW'(w_push) - CW'(w_pop);
  assign w_can_issue    = (w_count_next < CW'(DEPTH)) & w_fetch_en;
  assign w_redirect_pc  = i_redirect_pc & ~32'h3;
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

  assign o_valid          = (r_count != '0);
  assign o_instr          = r_instr_q[r_rd_ptr];
  assign o_pc             = r_pc_q[r_rd_ptr];
  assign mem_bus.mem_req  = r_mem_req;
  assign mem_bus.mem_addr = r_mem_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
`ifdef PQ_ALIGN_CHECK_EN
      r_addr_err <= 1'b0;
`endif
    end else if (i_redirect) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= w_redirect_pc;
`ifdef PQ_ALIGN_CHECK_EN
      r_addr_err <= |i_redirect_pc[1:0];
`endif
      // An in-flight request cannot be retracted, so its data is drained in DISCARD.
      if (r_state == ST_IDLE || w_ack) begin
        r_state   <= ST_IDLE;
        r_mem_req <= 1'b0;
      end else begin
        r_state <= ST_DISCARD;
      end
    end else begin
      if (w_push) begin
        r_instr_q[r_wr_ptr] <= mem_bus.mem_rdata;
        r_pc_q[r_wr_ptr]    <= r_fetch_pc;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_next;

      case (r_state)
        ST_IDLE: begin
          if (w_can_issue) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_ack) begin
            r_fetch_pc <= w_fetch_pc_inc;
            if (w_can_issue) begin
              r_mem_addr <= w_fetch_pc_inc;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (w_ack) begin
            if (w_can_issue) begin
              r_mem_addr <= r_fetch_pc;
              r_state    <= ST_WAIT;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
